// File: rtl/imem_port_arbiter_if.sv
// Signal bundle between the IF/LS requesters, the arbiter and the byte-pair memory port.
// Handshake: a requester holds *_req; the access is taken in any cycle where *_gnt is high.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_last;
    logic              if_abort;
    logic              if_gnt;
    logic              if_rvalid;
    logic [15:0]       if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [15:0]       ls_wdata;
    logic [1:0]        ls_be;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [15:0]       ls_rdata;

    logic [ADDR_W-1:0] mem_addr_low;
    logic [ADDR_W-1:0] mem_addr_high;
    logic              mem_we_low;
    logic              mem_we_high;
    logic [15:0]       mem_wdata;
    logic [7:0]        mem_rdata_low;
    logic [7:0]        mem_rdata_high;

    // 1 while the IF word lock is held
    logic              arb_state;

    modport slave (
        input  if_req, if_addr, if_last, if_abort,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_addr_low, mem_addr_high, mem_we_low, mem_we_high, mem_wdata,
        input  mem_rdata_low, mem_rdata_high,
        output arb_state
    );

    modport master (
        output if_req, if_addr, if_last, if_abort,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_addr_low, mem_addr_high, mem_we_low, mem_we_high, mem_wdata,
        output mem_rdata_low, mem_rdata_high,
        input  arb_state
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one byte-pair memory port between the IF refill engine and the LS unit:
// word-locked round-robin grant, two-cycle read pipeline, IF abort on redirect.
module imem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input logic clk,
    input logic rst,
    imem_port_arbiter_if.slave bus
);
    typedef enum logic {
        ARB_OPEN    = 1'b0,
        ARB_IF_LOCK = 1'b1
    } arb_state_t;

    arb_state_t state, state_n;
    logic       last_ls;
    logic       if_gnt, ls_gnt;

    logic       s1_valid, s1_owner_ls, s1_read;
    logic       if_rv_q, ls_rv_q;
    logic [15:0] if_resp_q, if_shown_q, ls_rdata_q, if_rdata_o;
    logic [ADDR_W-1:0] addr_low_q, addr_high_q;
    logic       we_low_q, we_high_q;
    logic [15:0] wdata_q;
    logic [15:0] mem_data;
    logic       if_capture, ls_capture;

    assign mem_data   = {bus.mem_rdata_high, bus.mem_rdata_low};
    assign if_capture = s1_valid && s1_read && !s1_owner_ls && !bus.if_abort;
    assign ls_capture = s1_valid && s1_read && s1_owner_ls;

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_OPEN;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if_gnt  = 1'b0;
        ls_gnt  = 1'b0;
        if (!rst) begin
            if (state == ARB_IF_LOCK && !bus.if_abort) begin
                if_gnt = bus.if_req;
            end else if (bus.if_req && !bus.if_abort && bus.ls_req) begin
                // tie: whoever did not own the port last time wins
                if_gnt = last_ls;
                ls_gnt = !last_ls;
            end else begin
                if_gnt = bus.if_req && !bus.if_abort;
                ls_gnt = bus.ls_req;
            end
            if (bus.if_abort) state_n = ARB_OPEN;
            if (if_gnt)       state_n = bus.if_last ? ARB_OPEN : ARB_IF_LOCK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ls <= 1'b1;
        end else if (if_gnt) begin
            last_ls <= 1'b0;
        end else if (ls_gnt) begin
            last_ls <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_low_q  <= '0;
            addr_high_q <= ADDR_W'(1);
            we_low_q    <= 1'b0;
            we_high_q   <= 1'b0;
            wdata_q     <= '0;
            s1_valid    <= 1'b0;
            s1_owner_ls <= 1'b0;
            s1_read     <= 1'b0;
            if_rv_q     <= 1'b0;
            ls_rv_q     <= 1'b0;
            if_resp_q   <= '0;
            if_shown_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            we_low_q  <= 1'b0;
            we_high_q <= 1'b0;
            s1_valid  <= if_gnt || ls_gnt;
            if (if_gnt) begin
                addr_low_q  <= bus.if_addr;
                addr_high_q <= bus.if_addr + ADDR_W'(1);
                s1_owner_ls <= 1'b0;
                s1_read     <= 1'b1;
            end else if (ls_gnt) begin
                addr_low_q  <= bus.ls_addr;
                addr_high_q <= bus.ls_addr + ADDR_W'(1);
                s1_owner_ls <= 1'b1;
                s1_read     <= !bus.ls_we;
                if (bus.ls_we) begin
                    we_low_q  <= bus.ls_be[0];
                    we_high_q <= bus.ls_be[1];
                    wdata_q   <= bus.ls_wdata;
                end
            end
            if_rv_q <= if_capture;
            ls_rv_q <= ls_capture;
            if (if_capture) if_resp_q <= mem_data;
            if (ls_capture) ls_rdata_q <= mem_data;
            // tracks what was presented so a masked response never disturbs the held value
            if_shown_q <= if_rdata_o;
        end
    end

    // an abort also suppresses an IF response that is already in the output register
    assign if_rdata_o = (if_rv_q && !bus.if_abort) ? if_resp_q : if_shown_q;

    assign bus.if_gnt        = if_gnt;
    assign bus.if_rvalid     = if_rv_q && !bus.if_abort;
    assign bus.if_rdata      = if_rdata_o;
    assign bus.ls_gnt        = ls_gnt;
    assign bus.ls_rvalid     = ls_rv_q;
    assign bus.ls_rdata      = ls_rdata_q;
    assign bus.mem_addr_low  = addr_low_q;
    assign bus.mem_addr_high = addr_high_q;
    assign bus.mem_we_low    = we_low_q;
    assign bus.mem_we_high   = we_high_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.arb_state     = state;
endmodule
